multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle main controller for the 16-bit datapath. It sequences fetch, decode, execute, memory and write-back as a Moore FSM, and drives the datapath strobes. It produces the 3-bit `alu_OP` consumed by `alu_control`: `011` selects R-type, decoded from the function field; any other value passes straight through as the ALU select. Memory accesses use a ready handshake, and the block counts retired instructions.

## Interface
- `CNT_W`, default 16: width of `retired_count`.
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 4: IR[15:12]; must be stable from the cycle after `ir_write`.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the access this cycle.
- `pc_write` out 1: PC load enable.
- `pc_src` out 2: PC source. `00` = PC+1, `01` = branch target, `10` = jump target.
- `ir_write` out 1: instruction register load.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `reg_write` out 1: register file write.
- `reg_dst` out 1: destination select. 1 = rd, 0 = rt.
- `alu_src` out 1: ALU B operand. 1 = immediate, 0 = register.
- `mem_to_reg` out 1: write-back source. 1 = memory data.
- `alu_OP` out 3: ALU operation (encodings under Operation).
- `illegal` out 1: pulse on an undefined opcode.
- `retire` out 1: pulse in the last cycle of each completed instruction.
- `halted` out 1: high while in HALT.
- `state` out 4: current state encoding, for debug.
- `retired_count` out `CNT_W`: count of retired instructions.

## Operation
- **Opcode map.** Any other opcode is illegal.
  - `0000` R-type
  - `0001` addi, `0010` andi, `0011` ori, `0100` xori
  - `1000` lw, `1001` sw
  - `1010` beq, `1011` bne
  - `1100` j
  - `1111` halt
- **ALU select codes** (`alu_OP` values other than `011`): add `000`, sub `010`, and `110`, or `111`, xor `001`.
- **State encodings:** FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_MEM=7, WB_ALU=8, BRANCH=9, JUMP=10, HALT=11.
- **Outputs** are decoded from the state register plus a registered decode: `alu_OP` and `reg_dst` are captured in DECODE. Any output not listed for a state is 0. `alu_OP` is `000` wherever not listed.
- **State behaviour:**
  - FETCH: `mem_read`=1. While `mem_ready`=0, stay. When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=00, go to DECODE.
  - DECODE:
    - R-type → EXEC_R.
    - addi/andi/ori/xori → EXEC_I.
    - lw/sw → ADDR.
    - beq/bne → BRANCH.
    - j → JUMP.
    - halt → HALT.
    - Illegal opcode: `illegal`=1, go to FETCH, no retire.
  - EXEC_R: `alu_OP`=011, `alu_src`=0 → WB_ALU.
  - EXEC_I: `alu_OP` = the op's code, `alu_src`=1 → WB_ALU.
  - WB_ALU: `reg_write`=1. `reg_dst`=1 for R-type, 0 for I-type. `alu_OP` holds its EXEC value. `retire`=1 → FETCH.
  - ADDR: `alu_OP`=000, `alu_src`=1. lw → MEM_RD, sw → MEM_WR.
  - MEM_RD: `mem_read`=1. Stay until `mem_ready`, then → WB_MEM.
  - WB_MEM: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `retire`=1 → FETCH.
  - MEM_WR: `mem_write`=1. Stay until `mem_ready`; `retire`=1 in the cycle `mem_ready`=1 → FETCH.
  - BRANCH: `alu_OP`=010, `alu_src`=0, `pc_src`=01. `pc_write` = `zero` for beq, `~zero` for bne. `retire`=1 → FETCH.
  - JUMP: `pc_write`=1, `pc_src`=10, `retire`=1 → FETCH.
  - HALT: `halted`=1; stays until reset. `retire`=1 only in the first HALT cycle.
- **Retire counter.** `retired_count` increments by 1 on each edge where `retire`=1. It wraps at 2^CNT_W−1 → 0 with no flag.

## Timing
- **Reset.** The edge with `reset`=1 forces state=FETCH, `retired_count`=0, and clears the registered decode.
  - The first post-reset cycle therefore shows `mem_read`=1; all other strobes are 0, `halted`=0, `alu_OP`=000.
  - Reset mid-instruction aborts it: no `reg_write`, `mem_write` or `pc_write` follows, and there is no retire.
  - Reset overrides everything, including `mem_ready` and HALT.
- **Latency with `mem_ready` tied high:**
  - R-type / I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branch / jump: 3 cycles.
  - Illegal: 2 cycles.
  - Each cycle `mem_ready` is low in FETCH, MEM_RD or MEM_WR adds exactly 1 cycle. The request stays asserted and unchanged while waiting.
- **Strobe rules.**
  - `mem_read` and `mem_write` are never high in the same cycle.
  - `ir_write` is high only on the FETCH cycle where `mem_ready`=1.
  - `pc_write` is high at most once per instruction outside FETCH.
- **`mem_ready` outside FETCH, MEM_RD and MEM_WR** is ignored.
- **`zero`** is sampled only in BRANCH.
- **`opcode`** is sampled only in DECODE. Changes to `opcode` elsewhere have no effect.

## Test plan
- **R-type, `mem_ready`=1, opcode `0000`:**
  - States 0,1,2,8.
  - `alu_OP`=011 in states 2 and 8.
  - Cycle 4: `reg_write`=1, `reg_dst`=1, `retire`=1.
  - `retired_count` goes 0→1.
- **lw, `mem_ready` held low for 2 cycles in MEM_RD:**
  - MEM_RD lasts 3 cycles, then WB_MEM with `mem_to_reg`=1.
  - Instruction total is 7 cycles.
- **ori (`0011`), then xori (`0100`):**
  - EXEC_I shows `alu_OP`=111, then 001.
  - `alu_src`=1, `reg_dst`=0 in WB_ALU.
- **Branch with `zero`=1:**
  - beq gives `pc_write`=1, `pc_src`=01, `alu_OP`=010.
  - bne with the same `zero` gives `pc_write`=0.
  - Both retire.
- **Illegal opcode `0111`:**
  - `illegal`=1 for exactly the DECODE cycle.
  - Next state is FETCH; `retired_count` is unchanged.
- **Halt and reset:**
  - halt (`1111`): `halted`=1, state=11 is held for 10+ cycles, `retired_count` increments once.
  - Then `reset` for 1 cycle: state=0, `retired_count`=0, `halted`=0, `mem_read`=1.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control/datapath strobe bundle for multicycle_control: opcode and status in,
// datapath enables, debug state and retire count out.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             reg_dst;
  logic             alu_src;
  logic             mem_to_reg;
  logic [2:0]       alu_OP;
  logic             illegal;
  logic             retire;
  logic             halted;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired_count;

  modport master (
    output opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, reg_dst,
           alu_src, mem_to_reg, alu_OP, illegal, retire, halted, state, retired_count
  );

  modport slave (
    input  opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, reg_dst,
           alu_src, mem_to_reg, alu_OP, illegal, retire, halted, state, retired_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle Moore controller for the 16-bit datapath: fetch/decode/execute/
// memory/write-back sequencing, ready-handshaked memory, retired-instruction count.
module multicycle_control #(
  parameter int unsigned CNT_W = 16
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_MEM = 4'd7,
    S_WB_ALU = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_HALT   = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       aop_q, aop_d;
  logic             rdst_q, rdst_d;
  logic             is_sw_q, is_sw_d;
  logic             is_bne_q, is_bne_d;
  logic             halt_seen_q;
  logic [CNT_W-1:0] cnt_q;

  logic       pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst;
  logic       alu_src, mem_to_reg, illegal, retire, halted;
  logic [1:0] pc_src;
  logic [2:0] alu_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      aop_q       <= '0;
      rdst_q      <= 1'b0;
      is_sw_q     <= 1'b0;
      is_bne_q    <= 1'b0;
      halt_seen_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      aop_q       <= aop_d;
      rdst_q      <= rdst_d;
      is_sw_q     <= is_sw_d;
      is_bne_q    <= is_bne_d;
      halt_seen_q <= (state_q == S_HALT);
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    aop_d      = aop_q;
    rdst_d     = rdst_q;
    is_sw_d    = is_sw_q;
    is_bne_d   = is_bne_q;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 3'b000;
    illegal    = 1'b0;
    retire     = 1'b0;
    halted     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Later states act only on this captured decode, so opcode may wander afterwards.
        aop_d    = 3'b000;
        rdst_d   = 1'b0;
        is_sw_d  = (bus.opcode == 4'b1001);
        is_bne_d = (bus.opcode == 4'b1011);
        case (bus.opcode)
          4'b0000: begin state_d = S_EXEC_R; aop_d = 3'b011; rdst_d = 1'b1; end
          4'b0001: begin state_d = S_EXEC_I; aop_d = 3'b000; end
          4'b0010: begin state_d = S_EXEC_I; aop_d = 3'b110; end
          4'b0011: begin state_d = S_EXEC_I; aop_d = 3'b111; end
          4'b0100: begin state_d = S_EXEC_I; aop_d = 3'b001; end
          4'b1000, 4'b1001: state_d = S_ADDR;
          4'b1010, 4'b1011: state_d = S_BRANCH;
          4'b1100: state_d = S_JUMP;
          4'b1111: state_d = S_HALT;
          default: begin illegal = 1'b1; state_d = S_FETCH; end
        endcase
      end
      S_EXEC_R: begin
        alu_op  = 3'b011;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_op  = aop_q;
        alu_src = 1'b1;
        state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = rdst_q;
        alu_op    = aop_q;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDR: begin
        alu_src = 1'b1;
        state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        if (bus.mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_op   = 3'b010;
        pc_src   = 2'b01;
        pc_write = is_bne_q ? ~bus.zero : bus.zero;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        retire = ~halt_seen_q;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_src        = pc_src;
  assign bus.ir_write      = ir_write;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.reg_write     = reg_write;
  assign bus.reg_dst       = reg_dst;
  assign bus.alu_src       = alu_src;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.alu_OP        = alu_op;
  assign bus.illegal       = illegal;
  assign bus.retire        = retire;
  assign bus.halted        = halted;
  assign bus.state         = state_q;
  assign bus.retired_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each instruction is expanded into its
// expected per-cycle output trace, which is then driven and compared cycle by cycle.
module tb_multicycle_control;

  localparam int unsigned CW = 3;

  logic clk;
  logic reset;

  multicycle_control_if #(.CNT_W(CW)) bus ();

  multicycle_control #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, rdy, zr;
    logic [3:0] op;
    bit         chk, lit;
    int         litv;
    logic [3:0] st;
    logic       mr, mw, irw, pcw;
    logic [1:0] ps;
    logic       rw, rd, as, m2r;
    logic [2:0] aop;
    logic       ill, ret, hlt;
  } cyc_t;

  cyc_t       q[$];
  logic [3:0] cur_op = 4'd0;
  int         n_assert = 0;
  int         n_fail = 0;
  int         mcnt = 0;
  int         cyc_no = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc_no, got, exp);
    end
  endtask

  // Outside DECODE/BRANCH/memory states opcode, zero and mem_ready carry junk.
  function automatic cyc_t mk(input logic [3:0] st);
    cyc_t c;
    c = '{default: '0};
    c.chk = 1'b1;
    c.st  = st;
    c.rdy = 1'b1;
    c.op  = ~cur_op;
    c.zr  = st[0];
    return c;
  endfunction

  function automatic logic legal(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd15};
  endfunction

  function automatic logic [2:0] icode(input logic [3:0] op);
    case (op)
      4'd1:    return 3'b000;
      4'd2:    return 3'b110;
      4'd3:    return 3'b111;
      default: return 3'b001;
    endcase
  endfunction

  task automatic do_reset();
    cyc_t c;
    c = mk(4'd0);
    c.rst = 1'b1;
    c.chk = 1'b0;
    q.push_back(c);
  endtask

  task automatic fetch(input int unsigned fw);
    cyc_t c;
    for (int unsigned i = 0; i < fw; i++) begin
      c = mk(4'd0); c.mr = 1; c.rdy = 0; q.push_back(c);
    end
    c = mk(4'd0); c.mr = 1; c.irw = 1; c.pcw = 1; q.push_back(c);
  endtask

  task automatic instr(input logic [3:0] op, input int unsigned fw, input int unsigned mwt,
                       input logic z, input int unsigned hx, output int n);
    cyc_t c;
    int n0;
    n0 = q.size();
    cur_op = op;
    fetch(fw);
    c = mk(4'd1); c.op = op; c.rdy = 1'b0; c.ill = ~legal(op); q.push_back(c);
    case (op)
      4'd0: begin
        c = mk(4'd2); c.aop = 3'b011; q.push_back(c);
        c = mk(4'd8); c.aop = 3'b011; c.rw = 1; c.rd = 1; c.ret = 1; q.push_back(c);
      end
      4'd1, 4'd2, 4'd3, 4'd4: begin
        c = mk(4'd3); c.aop = icode(op); c.as = 1; q.push_back(c);
        c = mk(4'd8); c.aop = icode(op); c.rw = 1; c.ret = 1; q.push_back(c);
      end
      4'd8: begin
        c = mk(4'd4); c.as = 1; q.push_back(c);
        for (int unsigned i = 0; i < mwt; i++) begin
          c = mk(4'd5); c.mr = 1; c.rdy = 0; q.push_back(c);
        end
        c = mk(4'd5); c.mr = 1; q.push_back(c);
        c = mk(4'd7); c.rw = 1; c.m2r = 1; c.ret = 1; q.push_back(c);
      end
      4'd9: begin
        c = mk(4'd4); c.as = 1; q.push_back(c);
        for (int unsigned i = 0; i < mwt; i++) begin
          c = mk(4'd6); c.mw = 1; c.rdy = 0; q.push_back(c);
        end
        c = mk(4'd6); c.mw = 1; c.ret = 1; q.push_back(c);
      end
      4'd10, 4'd11: begin
        c = mk(4'd9); c.zr = z; c.aop = 3'b010; c.ps = 2'b01; c.ret = 1;
        c.pcw = (op == 4'd11) ? ~z : z;
        q.push_back(c);
      end
      4'd12: begin
        c = mk(4'd10); c.pcw = 1; c.ps = 2'b10; c.ret = 1; q.push_back(c);
      end
      4'd15: begin
        c = mk(4'd11); c.hlt = 1; c.ret = 1; q.push_back(c);
        for (int unsigned i = 0; i < hx; i++) begin
          c = mk(4'd11); c.hlt = 1; c.rdy = i[0]; q.push_back(c);
        end
      end
      default: ;
    endcase
    n = q.size() - n0;
  endtask

  initial begin
    cyc_t c;
    int n;
    reset = 1'b0;
    bus.opcode = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;

    do_reset();
    instr(4'd0,  0, 0, 1'b0, 0, n); chk("lat_rtype", 32'(n), 32'd4);
    instr(4'd8,  0, 2, 1'b0, 0, n); chk("lat_lw_wait2", 32'(n), 32'd7);
    instr(4'd3,  0, 0, 1'b0, 0, n); chk("lat_ori", 32'(n), 32'd4);
    instr(4'd4,  0, 0, 1'b0, 0, n);
    instr(4'd10, 0, 0, 1'b1, 0, n); chk("lat_beq", 32'(n), 32'd3);
    instr(4'd11, 0, 0, 1'b1, 0, n);
    instr(4'd7,  0, 0, 1'b0, 0, n); chk("lat_illegal", 32'(n), 32'd2);
    instr(4'd9,  1, 1, 1'b0, 0, n); chk("lat_sw_waits", 32'(n), 32'd6);
    instr(4'd12, 0, 0, 1'b0, 0, n); chk("lat_jump", 32'(n), 32'd3);
    instr(4'd1,  0, 0, 1'b0, 0, n);
    instr(4'd2,  2, 0, 1'b0, 0, n);
    instr(4'd10, 0, 0, 1'b0, 0, n);
    instr(4'd11, 0, 0, 1'b0, 0, n);
    instr(4'd8,  0, 0, 1'b0, 0, n); chk("lat_lw", 32'(n), 32'd5);

    // lw aborted by reset while waiting in MEM_RD
    cur_op = 4'd8;
    fetch(0);
    c = mk(4'd1); c.op = 4'd8; q.push_back(c);
    c = mk(4'd4); c.as = 1; q.push_back(c);
    c = mk(4'd5); c.mr = 1; c.rdy = 0; q.push_back(c);
    do_reset();

    instr(4'd0,  0, 0, 1'b0, 0, n);
    instr(4'd9,  0, 0, 1'b0, 0, n);
    instr(4'd15, 0, 0, 1'b0, 12, n);
    q[q.size() - 1].lit  = 1'b1;
    q[q.size() - 1].litv = 3;
    do_reset();
    c = mk(4'd0); c.mr = 1; c.rdy = 0; q.push_back(c);
    c = mk(4'd0); c.mr = 1; c.rdy = 0; q.push_back(c);

    #1;
    foreach (q[k]) begin
      c = q[k];
      cyc_no = k;
      reset = c.rst;
      bus.mem_ready = c.rdy;
      bus.opcode = c.op;
      bus.zero = c.zr;
      #3;
      if (c.chk) begin
        chk("state",         32'(bus.state),         32'(c.st));
        chk("mem_read",      32'(bus.mem_read),      32'(c.mr));
        chk("mem_write",     32'(bus.mem_write),     32'(c.mw));
        chk("ir_write",      32'(bus.ir_write),      32'(c.irw));
        chk("pc_write",      32'(bus.pc_write),      32'(c.pcw));
        chk("pc_src",        32'(bus.pc_src),        32'(c.ps));
        chk("reg_write",     32'(bus.reg_write),     32'(c.rw));
        chk("reg_dst",       32'(bus.reg_dst),       32'(c.rd));
        chk("alu_src",       32'(bus.alu_src),       32'(c.as));
        chk("mem_to_reg",    32'(bus.mem_to_reg),    32'(c.m2r));
        chk("alu_OP",        32'(bus.alu_OP),        32'(c.aop));
        chk("illegal",       32'(bus.illegal),       32'(c.ill));
        chk("retire",        32'(bus.retire),        32'(c.ret));
        chk("halted",        32'(bus.halted),        32'(c.hlt));
        chk("retired_count", 32'(bus.retired_count), 32'(mcnt));
      end
      if (c.lit) chk("halt_count_literal", 32'(bus.retired_count), 32'(c.litv));
      @(posedge clk);
      #1;
      if (c.rst) mcnt = 0;
      else if (c.ret) mcnt = (mcnt + 1) % (1 << CW);
    end

    #3;
    chk("final_state",    32'(bus.state),         32'd0);
    chk("final_count",    32'(bus.retired_count), 32'd0);
    chk("final_halted",   32'(bus.halted),        32'd0);
    chk("final_mem_read", 32'(bus.mem_read),      32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
